// File: rtl/cnt_pkg.sv
// Shared constants and types for the up/down saturating/wrapping event counter.
package cnt_pkg;

  localparam logic CNT_DIR_UP = 1'b0;
  localparam logic CNT_DIR_DN = 1'b1;

  typedef enum logic {
    CNT_SAT,
    CNT_WRAP
  } cnt_mode_t;

endpackage

// File: rtl/addsub1_n.sv
// Combinational +-1 step of a WIDTH-bit value; dn_i selects decrement.
module addsub1_n
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             dn_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    if (dn_i == CNT_DIR_DN) begin
      y_o = a_i - WIDTH'(1);
    end else begin
      y_o = a_i + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sat_p.sv
// Up/down event counter with programmable terminal value, saturate or wrap at the bounds.
// Optional sticky bound-violation flag enabled by the CNT_OVF_STICKY_EN macro.
module counter_sat_p
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MAX_VAL = 33,
  parameter int unsigned WRAP    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             data_valid,
  input  logic             dn,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_zero,
  output logic             hit,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
  localparam cnt_mode_t        Mode = (WRAP != 0) ? CNT_WRAP : CNT_SAT;

  logic [WIDTH-1:0] cnt_q, cnt_d, step;
  logic             hit_q, hit_d;
  logic             is_max, is_zero;
  logic             count_en, up_at_bound, dn_at_bound;

  assign is_max   = (cnt_q == MaxV);
  assign is_zero  = (cnt_q == '0);
  // Only a real count cycle qualifies; clr/load take priority over the strobe.
  assign count_en    = data_valid && !clr && !load;
  assign up_at_bound = count_en && (dn == CNT_DIR_UP) && is_max;
  assign dn_at_bound = count_en && (dn == CNT_DIR_DN) && is_zero;

  addsub1_n #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a_i (cnt_q),
    .dn_i(dn),
    .y_o (step)
  );

  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (load_val > MaxV) ? MaxV : load_val;
    end else if (data_valid) begin
      if (up_at_bound) begin
        if (Mode == CNT_WRAP) cnt_d = '0;
      end else if (dn_at_bound) begin
        if (Mode == CNT_WRAP) cnt_d = MaxV;
      end else begin
        cnt_d = step;
        hit_d = (dn == CNT_DIR_UP) && (step == MaxV);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

`ifdef CNT_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (up_at_bound || dn_at_bound) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign cnt     = cnt_q;
  assign hit     = hit_q;
  assign at_max  = is_max;
  assign at_zero = is_zero;

endmodule

// File: tb/tb_counter_sat_p.sv
// Directed bench for counter_sat_p: one saturating and one wrapping instance, WIDTH=6, MAX_VAL=33.
module tb_counter_sat_p;

`ifdef CNT_OVF_STICKY_EN
  localparam bit OvfOn = 1'b1;
`else
  localparam bit OvfOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, dn, dv0, dv1;
  logic [5:0] load_val;
  logic [5:0] cnt0, cnt1;
  logic       at_max0, at_zero0, hit0, ovf0;
  logic       at_max1, at_zero1, hit1, ovf1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_sat_p #(.WIDTH(6), .MAX_VAL(33), .WRAP(0)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .data_valid(dv0),
    .dn        (dn),
    .cnt       (cnt0),
    .at_max    (at_max0),
    .at_zero   (at_zero0),
    .hit       (hit0),
    .ovf       (ovf0)
  );

  counter_sat_p #(.WIDTH(6), .MAX_VAL(33), .WRAP(1)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .data_valid(dv1),
    .dn        (dn),
    .cnt       (cnt1),
    .at_max    (at_max1),
    .at_zero   (at_zero1),
    .hit       (hit1),
    .ovf       (ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input int c, input bit h, input bit o);
    chk({tag, ".cnt0"}, 32'(cnt0), 32'(c));
    chk({tag, ".hit0"}, 32'(hit0), 32'(h));
    chk({tag, ".ovf0"}, 32'(ovf0), 32'(o));
  endtask

  task automatic chk1(input string tag, input int c, input bit h, input bit o);
    chk({tag, ".cnt1"}, 32'(cnt1), 32'(c));
    chk({tag, ".hit1"}, 32'(hit1), 32'(h));
    chk({tag, ".ovf1"}, 32'(ovf1), 32'(o));
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    dn       = 1'b0;
    dv0      = 1'b0;
    dv1      = 1'b0;
    load_val = '0;
    #12;
    chk0("reset", 0, 1'b0, 1'b0);
    chk1("reset", 0, 1'b0, 1'b0);
    chk("reset.at_zero0", 32'(at_zero0), 32'd1);
    chk("reset.at_max0", 32'(at_max0), 32'd0);
    chk("reset.at_zero1", 32'(at_zero1), 32'd1);
    rst_n = 1'b1;
    tick();

    // Saturating up count: 40 strobes from 0.
    dv0 = 1'b1;
    dn  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk0($sformatf("sat_up%0d", i), (i < 33) ? i : 33, (i == 33), OvfOn && (i >= 34));
      chk($sformatf("sat_up%0d.at_max0", i), 32'(at_max0), 32'(i >= 33));
    end
    dv0 = 1'b0;
    tick();
    chk0("sat_hold", 33, 1'b0, OvfOn);

    // Load clamp; ovf survives load.
    load     = 1'b1;
    load_val = 6'd50;
    tick();
    chk0("load50", 33, 1'b0, OvfOn);
    chk("load50.at_max0", 32'(at_max0), 32'd1);
    chk1("load50", 33, 1'b0, 1'b0);
    load_val = 6'd5;
    tick();
    chk0("load5", 5, 1'b0, OvfOn);
    chk("load5.at_max0", 32'(at_max0), 32'd0);

    // Priority: clr > load > data_valid.
    load_val = 6'd20;
    tick();
    chk0("load20", 20, 1'b0, OvfOn);
    clr      = 1'b1;
    dv0      = 1'b1;
    load_val = 6'd9;
    tick();
    chk0("clr_prio", 0, 1'b0, 1'b0);
    chk1("clr_prio", 0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    chk0("load_prio", 9, 1'b0, 1'b0);
    load = 1'b0;

    // Down step, then idle with unknown direction.
    dn = 1'b1;
    tick();
    chk0("down", 8, 1'b0, 1'b0);
    dv0 = 1'b0;
    dn  = 1'bx;
    tick();
    tick();
    chk0("idle_dnx", 8, 1'b0, 1'b0);

    // Down at zero saturates, sets ovf.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    dv0 = 1'b1;
    dn  = 1'b1;
    tick();
    chk0("sat_dn0", 0, 1'b0, OvfOn);
    chk("sat_dn0.at_zero0", 32'(at_zero0), 32'd1);

    // Count to 17, then asynchronous reset away from any edge.
    dv0      = 1'b0;
    load     = 1'b1;
    load_val = 6'd16;
    tick();
    load = 1'b0;
    dv0  = 1'b1;
    dn   = 1'b0;
    tick();
    chk0("pre_rst", 17, 1'b0, OvfOn);
    #2;
    rst_n = 1'b0;
    #1;
    chk0("async_rst", 0, 1'b0, 1'b0);
    chk("async_rst.at_zero0", 32'(at_zero0), 32'd1);
    dv0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Wrap instance: 34 up strobes, then one down at zero.
    dv1 = 1'b1;
    dn  = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      chk1($sformatf("wrap_up%0d", i), (i <= 33) ? i : 0, (i == 33), OvfOn && (i == 34));
    end
    dn = 1'b1;
    tick();
    chk1("wrap_dn0", 33, 1'b0, OvfOn);
    chk("wrap_dn0.at_max1", 32'(at_max1), 32'd1);
    dv1 = 1'b0;
    tick();
    chk1("wrap_hold", 33, 1'b0, OvfOn);
    chk0("sat_idle", 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
